// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dm_pkg
//  Purpose  : Shared definitions for the halfword-merge arbiter slice:
//             default widths, requester tag values and the result-register
//             state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam int DM_DATA_W = 32;
    localparam int DM_CNT_W  = 16;
    localparam int HALF_W    = DM_DATA_W / 2;

    // Requester identifiers, also used as the round-robin pointer value
    localparam logic TAG_REQ0 = 1'b0;
    localparam logic TAG_REQ1 = 1'b1;

    // Result register occupancy
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage : dm_pkg
`default_nettype wire

// File: rtl/dm_merge_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dm_merge_arbiter_if
//  Purpose  : Bundles the two requester channels, the result channel and the
//             zero-counter control/status of dm_merge_arbiter.
//  Ports    : req0/a0/b0/gnt0, req1/a1/b1/gnt1  - requester handshakes
//             out_valid/out_ready/out_data/out_zero/out_tag - result channel
//             clr_cnt/zero_cnt                  - zero-result counter
//  Modports : slave  - the arbiter
//             master - requesters + consumer
//  Revision : 1.0 - initial release
// ============================================================================
interface dm_merge_arbiter_if
    import dm_pkg::*;
#(
    parameter int DATA_W = DM_DATA_W,
    parameter int CNT_W  = DM_CNT_W
) ();

    logic              req0;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] b0;
    logic              gnt0;
    logic              req1;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic              gnt1;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_zero;
    logic              out_tag;
    logic              clr_cnt;
    logic [CNT_W-1:0]  zero_cnt;

    modport slave (
        input  req0, a0, b0, req1, a1, b1, out_ready, clr_cnt,
        output gnt0, gnt1, out_valid, out_data, out_zero, out_tag, zero_cnt
    );

    modport master (
        output req0, a0, b0, req1, a1, b1, out_ready, clr_cnt,
        input  gnt0, gnt1, out_valid, out_data, out_zero, out_tag, zero_cnt
    );

endinterface : dm_merge_arbiter_if
`default_nettype wire

// File: rtl/dm_merge_core.sv
`default_nettype none
// ============================================================================
//  Module   : dm_merge_core
//  Purpose  : Combinational halfword merge: upper half of b, lower half of a,
//             plus an all-zero flag for the merged value.
//  Ports    : a, b   - operands
//             merged - {b[DATA_W-1:DATA_W/2], a[DATA_W/2-1:0]}
//             zero   - merged == 0
//  Revision : 1.0 - initial release
// ============================================================================
module dm_merge_core
    import dm_pkg::*;
#(
    parameter int DATA_W = DM_DATA_W
) (
    input  wire logic [DATA_W-1:0] a,
    input  wire logic [DATA_W-1:0] b,
    output logic      [DATA_W-1:0] merged,
    output logic                   zero
);

    localparam int H = DATA_W / 2;

    // The discarded halves are intentionally dropped
    logic w_unused_halves;
    assign w_unused_halves = ^{a[DATA_W-1:H], b[H-1:0]};

    assign merged = {b[DATA_W-1:H], a[H-1:0]};
    assign zero   = ~|merged;

endmodule : dm_merge_core
`default_nettype wire

// File: rtl/dm_merge_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dm_merge_arbiter
//  Purpose  : Round-robin arbiter sharing one halfword-merge unit between two
//             requesters, with a one-entry registered result stage
//             (valid/ready), requester tagging and a saturating count of
//             delivered zero results.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             bus    - dm_merge_arbiter_if.slave (requesters, result, counter)
//  Revision : 1.0 - initial release
// ============================================================================
module dm_merge_arbiter
    import dm_pkg::*;
#(
    parameter int DATA_W = DM_DATA_W,
    parameter int CNT_W  = DM_CNT_W
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    dm_merge_arbiter_if.slave bus
);

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              zero_q, zero_d;
    logic              tag_q, tag_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  zero_cnt_q, zero_cnt_d;

    logic              w_out_valid;
    logic              w_can_accept;
    logic              w_gnt0, w_gnt1, w_grant, w_win;
    logic [DATA_W-1:0] w_op_a, w_op_b, w_merged;
    logic              w_merged_zero;

    // ------------------------------------------------------------------
    // Arbitration. Grants are suppressed while reset is held so that a
    // requester never sees an acceptance that the flops will discard.
    // ------------------------------------------------------------------
    always_comb begin
        w_can_accept = !w_out_valid || bus.out_ready;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        if (rst_n && w_can_accept) begin
            if (bus.req0 && bus.req1) begin
                if (rr_ptr_q == TAG_REQ0) w_gnt0 = 1'b1;
                else                      w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = bus.req0;
                w_gnt1 = bus.req1;
            end
        end
    end

    assign w_grant = w_gnt0 | w_gnt1;
    assign w_win   = w_gnt1 ? TAG_REQ1 : TAG_REQ0;
    assign w_op_a  = w_gnt1 ? bus.a1 : bus.a0;
    assign w_op_b  = w_gnt1 ? bus.b1 : bus.b0;

    dm_merge_core #(
        .DATA_W (DATA_W)
    ) u_merge (
        .a      (w_op_a),
        .b      (w_op_b),
        .merged (w_merged),
        .zero   (w_merged_zero)
    );

    // ------------------------------------------------------------------
    // Result-register occupancy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (w_grant)                     state_d = ST_FULL;
            ST_FULL:  if (bus.out_ready && !w_grant)   state_d = ST_EMPTY;
            default:                                   state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        w_out_valid = (state_q == ST_FULL);
    end

    // ------------------------------------------------------------------
    // Result payload, round-robin pointer and zero counter. A grant only
    // happens when the register can accept, so "grant" alone decides load.
    // ------------------------------------------------------------------
    always_comb begin
        data_d     = data_q;
        zero_d     = zero_q;
        tag_d      = tag_q;
        rr_ptr_d   = rr_ptr_q;
        zero_cnt_d = zero_cnt_q;

        if (w_grant) begin
            data_d   = w_merged;
            zero_d   = w_merged_zero;
            tag_d    = w_win;
            rr_ptr_d = ~w_win;
        end

        if (bus.clr_cnt) begin
            zero_cnt_d = '0;
        end else if (w_out_valid && bus.out_ready && zero_q && (zero_cnt_q != {CNT_W{1'b1}})) begin
            zero_cnt_d = zero_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            zero_q     <= 1'b0;
            tag_q      <= TAG_REQ0;
            rr_ptr_q   <= TAG_REQ0;
            zero_cnt_q <= '0;
        end else begin
            data_q     <= data_d;
            zero_q     <= zero_d;
            tag_q      <= tag_d;
            rr_ptr_q   <= rr_ptr_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = data_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_tag   = tag_q;
    assign bus.zero_cnt  = zero_cnt_q;

endmodule : dm_merge_arbiter
`default_nettype wire

// File: tb/tb_dm_merge_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_merge_arbiter
//  Purpose  : Self-checking bench for dm_merge_arbiter: directed scenarios
//             with literal expectations, a small-counter instance for
//             saturation, and randomized traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_merge_arbiter;

    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int CMAX  = 65535;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dm_merge_arbiter_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    dm_merge_arbiter_if #(.DATA_W(DW), .CNT_W(2))  sbus ();

    dm_merge_arbiter #(.DATA_W(DW), .CNT_W(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dm_merge_arbiter #(.DATA_W(DW), .CNT_W(2)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one result slot, a pointer saying who wins a tie,
    // and a counter of delivered zero results.
    // ------------------------------------------------------------------
    logic            m_valid, m_zero, m_tag, m_rr;
    logic [DW-1:0]   m_data;
    int              m_cnt;
    logic            eg0 = 1'b0, eg1 = 1'b0;
    logic            m_can;
    logic [DW-1:0]   m_a, m_b;

    always @(negedge clk) begin
        if (rst_n) begin
            m_can = !m_valid || bus.out_ready;
            eg0 = m_can && bus.req0 && (!bus.req1 || m_rr == 1'b0);
            eg1 = m_can && bus.req1 && (!bus.req0 || m_rr == 1'b1);
            check("gnt0",      64'(bus.gnt0),      64'(eg0));
            check("gnt1",      64'(bus.gnt1),      64'(eg1));
            check("out_valid", 64'(bus.out_valid), 64'(m_valid));
            check("out_data",  64'(bus.out_data),  64'(m_data));
            check("out_zero",  64'(bus.out_zero),  64'(m_zero));
            check("out_tag",   64'(bus.out_tag),   64'(m_tag));
            check("zero_cnt",  64'(bus.zero_cnt),  64'(m_cnt));
        end else begin
            eg0 = 1'b0;
            eg1 = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_zero = 1'b0; m_tag = 1'b0; m_rr = 1'b0;
            m_data  = '0;   m_cnt  = 0;
        end else begin
            if (bus.clr_cnt)
                m_cnt = 0;
            else if (m_valid && bus.out_ready && m_zero && m_cnt < CMAX)
                m_cnt = m_cnt + 1;

            if (eg0 || eg1) begin
                m_a     = eg1 ? bus.a1 : bus.a0;
                m_b     = eg1 ? bus.b1 : bus.b0;
                m_data  = (m_b & 32'hFFFF_0000) | (m_a & 32'h0000_FFFF);
                m_zero  = (m_data == 0);
                m_tag   = eg1;
                m_valid = 1'b1;
                m_rr    = !eg1;
            end else if (!m_valid || bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_op();
        logic [DW-1:0] v;
        v = $urandom;
        if ($urandom_range(0, 2) == 0) v[15:0]  = '0;
        if ($urandom_range(0, 2) == 0) v[31:16] = '0;
        return v;
    endfunction

    int sat_exp [7] = '{0, 0, 1, 2, 3, 3, 3};

    initial begin
        rst_n         = 1'b0;
        bus.req0      = 1'b0; bus.a0 = '0; bus.b0 = '0;
        bus.req1      = 1'b0; bus.a1 = '0; bus.b1 = '0;
        bus.out_ready = 1'b0; bus.clr_cnt = 1'b0;
        sbus.req0     = 1'b0; sbus.a0 = '0; sbus.b0 = '0;
        sbus.req1     = 1'b0; sbus.a1 = '0; sbus.b1 = '0;
        sbus.out_ready = 1'b0; sbus.clr_cnt = 1'b0;

        // Reset state; a request during reset must not be granted
        repeat (2) @(posedge clk);
        #1 bus.req0 = 1'b1;
        @(negedge clk);
        check("rst_gnt0",      64'(bus.gnt0),      64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_tag",   64'(bus.out_tag),   64'd0);
        check("rst_zero_cnt",  64'(bus.zero_cnt),  64'd0);
        tick();
        bus.req0 = 1'b0;
        rst_n    = 1'b1;

        // Single request
        bus.req0 = 1'b1; bus.a0 = 32'h1111_ABCD; bus.b0 = 32'h5678_2222;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("single_gnt0", 64'(bus.gnt0), 64'd1);
        check("single_gnt1", 64'(bus.gnt1), 64'd0);
        tick();
        bus.req0 = 1'b0;
        @(negedge clk);
        check("single_valid", 64'(bus.out_valid), 64'd1);
        check("single_data",  64'(bus.out_data),  64'h5678_ABCD);
        check("single_zero",  64'(bus.out_zero),  64'd0);
        check("single_tag",   64'(bus.out_tag),   64'd0);
        tick();

        // Contention: pointer moved to 1 after the single grant -> 1,0,1,0
        bus.req0 = 1'b1; bus.a0 = 32'hAAAA_0A0A; bus.b0 = 32'h0B0B_BBBB;
        bus.req1 = 1'b1; bus.a1 = 32'hCCCC_0C0C; bus.b1 = 32'h0D0D_DDDD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("cont_gnt1", 64'(bus.gnt1), 64'((i % 2) == 0));
            if (i > 0) begin
                check("cont_tag",   64'(bus.out_tag),   64'((i % 2) == 1));
                check("cont_valid", 64'(bus.out_valid), 64'd1);
            end
            tick();
        end

        // Backpressure: result from requester 0 pending, requester 1 waits
        bus.req0 = 1'b0; bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_gnt1",  64'(bus.gnt1),     64'd0);
            check("bp_data",  64'(bus.out_data), 64'h0B0B_0A0A);
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_gnt1", 64'(bus.gnt1), 64'd1);
        tick();
        bus.req1 = 1'b0;
        @(negedge clk);
        check("bp_new_tag",  64'(bus.out_tag),  64'd1);
        check("bp_new_data", 64'(bus.out_data), 64'h0D0D_0C0C);
        tick();

        // Zero results and counter clear
        bus.req0 = 1'b1; bus.a0 = 32'hFFFF_0000; bus.b0 = 32'h0000_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) check("zero_flag", 64'(bus.out_zero), 64'd1);
            tick();
        end
        bus.req0 = 1'b0; bus.clr_cnt = 1'b1;
        @(negedge clk);
        check("zero_cnt3", 64'(bus.zero_cnt), 64'd3);
        tick();
        bus.clr_cnt = 1'b0;
        @(negedge clk);
        check("zero_clr", 64'(bus.zero_cnt), 64'd0);
        tick();

        // Saturation on the 2-bit counter instance
        sbus.req0 = 1'b1; sbus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("sat_cnt", 64'(sbus.zero_cnt), 64'(sat_exp[i]));
            tick();
        end
        sbus.req0 = 1'b0;

        // Async reset while a result is stalled
        bus.req0 = 1'b1; bus.out_ready = 1'b1;
        tick();
        tick();
        bus.req0 = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_cnt",   64'(bus.zero_cnt),  64'd1);
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.a1 = 32'h0000_0001; bus.b1 = 32'h0001_0000;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_cnt",   64'(bus.zero_cnt),  64'd0);
        check("arst_data",  64'(bus.out_data),  64'd0);
        check("arst_gnt0",  64'(bus.gnt0),      64'd0);
        check("arst_gnt1",  64'(bus.gnt1),      64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_gnt0", 64'(bus.gnt0), 64'd1);
        check("post_rst_gnt1", 64'(bus.gnt1), 64'd0);
        tick();

        // Randomized traffic; a waiting requester mostly holds its request
        for (int n = 0; n < 3000; n++) begin
            if (!(bus.req0 && !eg0) || $urandom_range(0, 9) == 0) begin
                bus.req0 = $urandom_range(0, 1) == 1;
                bus.a0   = rnd_op();
                bus.b0   = rnd_op();
            end
            if (!(bus.req1 && !eg1) || $urandom_range(0, 9) == 0) begin
                bus.req1 = $urandom_range(0, 1) == 1;
                bus.a1   = rnd_op();
                bus.b1   = rnd_op();
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.clr_cnt   = $urandom_range(0, 31) == 0;
            tick();
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.clr_cnt = 1'b0; bus.out_ready = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_dm_merge_arbiter
`default_nettype wire
